// File: rtl/time_set_ctrl_if.sv
// ---------------------------------------------------------------------------
// time_set_ctrl_if
// Bundles the key pulses, the running-time inputs, and the time/alarm/display
// outputs of time_set_ctrl.
//   master : drives keys and running time, observes the editor outputs
//   slave  : the editor itself (time_set_ctrl)
// All digits are BCD nibbles (ge = units, shi = tens).
// ---------------------------------------------------------------------------
interface time_set_ctrl_if;
  // one-cycle debounced key pulses
  logic       key_mode;
  logic       key_next;
  logic       key_inc;
  logic       key_dec;

  // running time from time_control
  logic [3:0] cur_sec_ge;
  logic [3:0] cur_sec_shi;
  logic [3:0] cur_min_ge;
  logic [3:0] cur_min_shi;
  logic [3:0] cur_hour_ge;
  logic [3:0] cur_hour_shi;

  // time to load into time_control, held between commits
  logic [3:0] set_sec_ge;
  logic [3:0] set_sec_shi;
  logic [3:0] set_min_ge;
  logic [3:0] set_min_shi;
  logic [3:0] set_hour_ge;
  logic [3:0] set_hour_shi;
  logic       set_time_finish;

  // alarm settings, held between commits
  logic       clock_en;
  logic [3:0] clock_min_ge;
  logic [3:0] clock_min_shi;
  logic [3:0] clock_hour_ge;
  logic [3:0] clock_hour_shi;

  // display hints
  logic [2:0] edit_field;
  logic       blink_off;

  modport master (
    output key_mode, key_next, key_inc, key_dec,
    output cur_sec_ge, cur_sec_shi, cur_min_ge, cur_min_shi, cur_hour_ge, cur_hour_shi,
    input  set_sec_ge, set_sec_shi, set_min_ge, set_min_shi, set_hour_ge, set_hour_shi,
    input  set_time_finish,
    input  clock_en, clock_min_ge, clock_min_shi, clock_hour_ge, clock_hour_shi,
    input  edit_field, blink_off
  );

  modport slave (
    input  key_mode, key_next, key_inc, key_dec,
    input  cur_sec_ge, cur_sec_shi, cur_min_ge, cur_min_shi, cur_hour_ge, cur_hour_shi,
    output set_sec_ge, set_sec_shi, set_min_ge, set_min_shi, set_hour_ge, set_hour_shi,
    output set_time_finish,
    output clock_en, clock_min_ge, clock_min_shi, clock_hour_ge, clock_hour_shi,
    output edit_field, blink_off
  );
endinterface

// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// time_set_ctrl
// Key-driven editor for the clock time and the alarm time. Four one-cycle key
// pulses walk through the hour/min/sec (time) or hour/min (alarm) fields,
// adjust them in packed two-digit BCD, and commit the result. A cursor code
// and a blink flag tell the display which field is being edited.
//
// Ports
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : time_set_ctrl_if.slave
//            in : key_mode/key_next/key_inc/key_dec, cur_* running time
//            out: set_* + set_time_finish, clock_en + clock_*, edit_field,
//                 blink_off
//
// State      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | not editing; inc/dec toggle the alarm enable
// S_T_HOUR   | editing time hour field
// S_T_MIN    | editing time minute field
// S_T_SEC    | editing time second field
// S_T_COMMIT | one cycle: set_* hold the new time, set_time_finish high
// S_A_HOUR   | editing alarm hour field
// S_A_MIN    | editing alarm minute field
// S_A_COMMIT | one cycle: clock_* hold the new alarm
// ---------------------------------------------------------------------------
module time_set_ctrl #(
  parameter int unsigned BLINK_HALF  = 12_500_000,
  parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
  input  logic           clk,
  input  logic           rst,
  time_set_ctrl_if.slave bus
);

  localparam int unsigned BL_W = (BLINK_HALF  > 1) ? $clog2(BLINK_HALF)  : 1;
  localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  // Both timers are down-counters reloaded on restart; terminal count is 0.
  localparam logic [BL_W-1:0] BL_LOAD = BL_W'(BLINK_HALF - 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYC - 1);

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MS_MAX   = 8'h59;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T_HOUR,
    S_T_MIN,
    S_T_SEC,
    S_T_COMMIT,
    S_A_HOUR,
    S_A_MIN,
    S_A_COMMIT
  } state_t;

  state_t          state;
  state_t          state_nxt;

  // working copies being edited
  logic [7:0]      w_hour;
  logic [7:0]      w_min;
  logic [7:0]      w_sec;
  logic [7:0]      wa_hour;
  logic [7:0]      wa_min;

  // registered outputs
  logic [7:0]      set_hour;
  logic [7:0]      set_min;
  logic [7:0]      set_sec;
  logic            set_fin_q;
  logic [7:0]      alm_hour;
  logic [7:0]      alm_min;
  logic            clock_en_q;
  logic [2:0]      field_q;
  logic            blink_q;

  logic [BL_W-1:0] blink_cnt;
  logic [TO_W-1:0] tmo_cnt;

  logic            key_any;
  logic            act_inc;
  logic            act_dec;
  logic            in_edit;
  logic            in_tedit;
  logic            tmo_hit;
  logic            tmr_clr;

  // Cursor code shown to the display for a given state.
  function automatic logic [2:0] field_of(input state_t s);
    logic [2:0] f;
    case (s)
      S_T_HOUR: f = 3'd1;
      S_T_MIN:  f = 3'd2;
      S_T_SEC:  f = 3'd3;
      S_A_HOUR: f = 3'd4;
      S_A_MIN:  f = 3'd5;
      default:  f = 3'd0;
    endcase
    return f;
  endfunction

  // One step up or down on a packed two-digit BCD field with range 00..max.
  function automatic logic [7:0] bcd_step(input logic [7:0] v,
                                          input logic [7:0] max,
                                          input logic       up);
    logic [7:0] r;
    if (up) begin
      if (v == max)            r = 8'h00;
      else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
      else                     r = {v[7:4], v[3:0] + 4'd1};
    end else begin
      if (v == 8'h00)          r = max;
      else if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
      else                     r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  // Key priority: mode > next > inc/dec. inc and dec together cancel out but
  // still count as activity for the timers.
  assign key_any  = bus.key_mode | bus.key_next | bus.key_inc | bus.key_dec;
  assign act_inc  = ~bus.key_mode & ~bus.key_next &  bus.key_inc & ~bus.key_dec;
  assign act_dec  = ~bus.key_mode & ~bus.key_next & ~bus.key_inc &  bus.key_dec;
  assign in_edit  = (field_q != 3'd0);
  assign in_tedit = (state == S_T_HOUR) || (state == S_T_MIN) || (state == S_T_SEC);
  assign tmo_hit  = in_edit && !key_any && (tmo_cnt == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.key_mode) state_nxt = S_T_HOUR;
      end
      S_T_HOUR, S_T_MIN, S_T_SEC: begin
        if (bus.key_mode) begin
          state_nxt = S_A_HOUR;
        end else if (bus.key_next) begin
          if (state == S_T_HOUR)     state_nxt = S_T_MIN;
          else if (state == S_T_MIN) state_nxt = S_T_SEC;
          else                       state_nxt = S_T_COMMIT;
        end else if (tmo_hit) begin
          state_nxt = S_IDLE;
        end
      end
      S_A_HOUR, S_A_MIN: begin
        if (bus.key_mode) begin
          state_nxt = S_IDLE;
        end else if (bus.key_next) begin
          state_nxt = (state == S_A_HOUR) ? S_A_MIN : S_A_COMMIT;
        end else if (tmo_hit) begin
          state_nxt = S_IDLE;
        end
      end
      // commit cycles ignore every key
      default: state_nxt = S_IDLE;
    endcase
  end

  assign tmr_clr = key_any || (state_nxt != state);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      field_q    <= 3'd0;
      w_hour     <= 8'h00;
      w_min      <= 8'h00;
      w_sec      <= 8'h00;
      wa_hour    <= 8'h00;
      wa_min     <= 8'h00;
      set_hour   <= 8'h00;
      set_min    <= 8'h00;
      set_sec    <= 8'h00;
      set_fin_q  <= 1'b0;
      alm_hour   <= 8'h00;
      alm_min    <= 8'h00;
      clock_en_q <= 1'b0;
      blink_q    <= 1'b0;
      blink_cnt  <= '0;
      tmo_cnt    <= '0;
    end else begin
      state   <= state_nxt;
      field_q <= field_of(state_nxt);

      // Outputs are loaded on the edge into the commit state so the new
      // value is already on the bus while the strobe is high.
      set_fin_q <= (state_nxt == S_T_COMMIT);
      if (state_nxt == S_T_COMMIT) begin
        set_hour <= w_hour;
        set_min  <= w_min;
        set_sec  <= w_sec;
      end
      if (state_nxt == S_A_COMMIT) begin
        alm_hour <= wa_hour;
        alm_min  <= wa_min;
      end

      if ((state == S_IDLE) && (act_inc || act_dec))
        clock_en_q <= ~clock_en_q;

      if ((state == S_IDLE) && bus.key_mode) begin
        w_hour <= {bus.cur_hour_shi, bus.cur_hour_ge};
        w_min  <= {bus.cur_min_shi,  bus.cur_min_ge};
        w_sec  <= {bus.cur_sec_shi,  bus.cur_sec_ge};
      end

      // Leaving time edit for alarm edit starts from the committed alarm.
      if (in_tedit && bus.key_mode) begin
        wa_hour <= alm_hour;
        wa_min  <= alm_min;
      end

      if (act_inc || act_dec) begin
        case (state)
          S_T_HOUR: w_hour  <= bcd_step(w_hour,  HOUR_MAX, act_inc);
          S_T_MIN:  w_min   <= bcd_step(w_min,   MS_MAX,   act_inc);
          S_T_SEC:  w_sec   <= bcd_step(w_sec,   MS_MAX,   act_inc);
          S_A_HOUR: wa_hour <= bcd_step(wa_hour, HOUR_MAX, act_inc);
          S_A_MIN:  wa_min  <= bcd_step(wa_min,  MS_MAX,   act_inc);
          default: ;
        endcase
      end

      if (tmr_clr) begin
        tmo_cnt <= TO_LOAD;
      end else if (in_edit && (tmo_cnt != '0)) begin
        tmo_cnt <= tmo_cnt - TO_W'(1);
      end

      // Blink restarts with the field visible after any key or state change,
      // and stays visible when no field is selected.
      if (tmr_clr || (field_of(state_nxt) == 3'd0)) begin
        blink_cnt <= BL_LOAD;
        blink_q   <= 1'b0;
      end else if (blink_cnt == '0) begin
        blink_cnt <= BL_LOAD;
        blink_q   <= ~blink_q;
      end else begin
        blink_cnt <= blink_cnt - BL_W'(1);
      end
    end
  end

  assign bus.set_hour_shi    = set_hour[7:4];
  assign bus.set_hour_ge     = set_hour[3:0];
  assign bus.set_min_shi     = set_min[7:4];
  assign bus.set_min_ge      = set_min[3:0];
  assign bus.set_sec_shi     = set_sec[7:4];
  assign bus.set_sec_ge      = set_sec[3:0];
  assign bus.set_time_finish = set_fin_q;
  assign bus.clock_en        = clock_en_q;
  assign bus.clock_hour_shi  = alm_hour[7:4];
  assign bus.clock_hour_ge   = alm_hour[3:0];
  assign bus.clock_min_shi   = alm_min[7:4];
  assign bus.clock_min_ge    = alm_min[3:0];
  assign bus.edit_field      = field_q;
  assign bus.blink_off       = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;

  logic clk = 1'b0;
  logic rst;

  time_set_ctrl_if ts();

  time_set_ctrl #(
    .BLINK_HALF (4),
    .TIMEOUT_CYC(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ts)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int h;
    int m;
    int s;
  } commit_t;

  commit_t exp_q[$];

  // reference model: fields held as plain integers
  int st;                  // 0 idle, 1..3 time fields, 4..5 alarm fields
  int wh, wm, ws;          // working time
  int wah, wam;            // working alarm
  int sh, sm, ss;          // committed time
  int ah, am;              // committed alarm
  int cen;
  int cur_h, cur_m, cur_s;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [23:0] dut_set();
    return {ts.set_hour_shi, ts.set_hour_ge, ts.set_min_shi, ts.set_min_ge,
            ts.set_sec_shi, ts.set_sec_ge};
  endfunction

  function automatic logic [15:0] dut_alarm();
    return {ts.clock_hour_shi, ts.clock_hour_ge, ts.clock_min_shi, ts.clock_min_ge};
  endfunction

  function automatic int step(input int v, input int lim, input bit up);
    return up ? (v + 1) % lim : (v + lim - 1) % lim;
  endfunction

  task automatic model_reset();
    st = 0; wh = 0; wm = 0; ws = 0; wah = 0; wam = 0;
    sh = 0; sm = 0; ss = 0; ah = 0; am = 0; cen = 0;
  endtask

  task automatic model_key(input bit m, input bit n, input bit i, input bit d);
    commit_t c;
    if (m) begin
      if (st == 0) begin
        wh = cur_h; wm = cur_m; ws = cur_s; st = 1;
      end else if (st <= 3) begin
        wah = ah; wam = am; st = 4;
      end else begin
        st = 0;
      end
    end else if (n) begin
      case (st)
        1: st = 2;
        2: st = 3;
        3: begin
          c.h = wh; c.m = wm; c.s = ws;
          exp_q.push_back(c);
          sh = wh; sm = wm; ss = ws;
          st = 0;
        end
        4: st = 5;
        5: begin
          ah = wah; am = wam;
          st = 0;
        end
        default: ;
      endcase
    end else if (i != d) begin
      case (st)
        0: cen = 1 - cen;
        1: wh  = step(wh, 24, i);
        2: wm  = step(wm, 60, i);
        3: ws  = step(ws, 60, i);
        4: wah = step(wah, 24, i);
        5: wam = step(wam, 60, i);
        default: ;
      endcase
    end
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    cur_h = h; cur_m = m; cur_s = s;
    ts.cur_hour_shi = 4'(h / 10); ts.cur_hour_ge = 4'(h % 10);
    ts.cur_min_shi  = 4'(m / 10); ts.cur_min_ge  = 4'(m % 10);
    ts.cur_sec_shi  = 4'(s / 10); ts.cur_sec_ge  = 4'(s % 10);
  endtask

  // One key pulse for one cycle, then check the cursor on the following cycle.
  task automatic press(input bit m, input bit n, input bit i, input bit d);
    @(negedge clk);
    ts.key_mode = m; ts.key_next = n; ts.key_inc = i; ts.key_dec = d;
    model_key(m, n, i, d);
    @(negedge clk);
    ts.key_mode = 1'b0; ts.key_next = 1'b0; ts.key_inc = 1'b0; ts.key_dec = 1'b0;
    chk("edit_field", int'(ts.edit_field), st);
    chk("blink_after_key", int'(ts.blink_off), 0);
    chk("clock_en", int'(ts.clock_en), cen);
  endtask

  task automatic press_n(input bit m, input bit n, input bit i, input bit d, input int cnt);
    for (int k = 0; k < cnt; k++) press(m, n, i, d);
  endtask

  // Commit monitor: every strobe must match the oldest expected commit.
  always @(negedge clk) begin : commit_mon
    commit_t e;
    if (ts.set_time_finish === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("strobe_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("commit_hour", int'({ts.set_hour_shi, ts.set_hour_ge}), int'(bcd(e.h)));
        chk("commit_min",  int'({ts.set_min_shi,  ts.set_min_ge}),  int'(bcd(e.m)));
        chk("commit_sec",  int'({ts.set_sec_shi,  ts.set_sec_ge}),  int'(bcd(e.s)));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int r;
    ts.key_mode = 1'b0; ts.key_next = 1'b0; ts.key_inc = 1'b0; ts.key_dec = 1'b0;
    set_cur(0, 0, 0);
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_set",    int'(dut_set()), 0);
    chk("rst_alarm",  int'(dut_alarm()), 0);
    chk("rst_en",     int'(ts.clock_en), 0);
    chk("rst_field",  int'(ts.edit_field), 0);
    chk("rst_blink",  int'(ts.blink_off), 0);
    chk("rst_strobe", int'(ts.set_time_finish), 0);

    // basic time set from 12:34:56
    set_cur(12, 34, 56);
    press(1, 0, 0, 0);
    press_n(0, 1, 0, 0, 3);
    chk("t1_set", int'(dut_set()), 24'h123456);
    @(negedge clk);
    chk("t1_strobe_width", int'(ts.set_time_finish), 0);

    // hour wrap up and down
    press(1, 0, 0, 0);
    press_n(0, 0, 1, 0, 12);
    press(0, 0, 0, 1);
    press_n(0, 1, 0, 0, 3);
    chk("t2_set", int'(dut_set()), 24'h233456);

    // min 59 -> 00, sec 00 -> 59
    set_cur(10, 59, 0);
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    press(0, 0, 1, 0);
    press(0, 1, 0, 0);
    press(0, 0, 0, 1);
    press(0, 1, 0, 0);
    chk("t3_set", int'(dut_set()), 24'h100059);

    // units carry 09 -> 10
    set_cur(0, 0, 9);
    press(1, 0, 0, 0);
    press_n(0, 1, 0, 0, 2);
    press(0, 0, 1, 0);
    press(0, 1, 0, 0);
    chk("t4_set", int'(dut_set()), 24'h000010);

    // alarm path 07:30
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    chk("a_field", int'(ts.edit_field), 4);
    press_n(0, 0, 1, 0, 7);
    press(0, 1, 0, 0);
    press_n(0, 0, 1, 0, 30);
    press(0, 1, 0, 0);
    chk("a_alarm", int'(dut_alarm()), 16'h0730);
    chk("a_en_kept", int'(ts.clock_en), 0);
    press(0, 0, 1, 0);
    chk("a_en_toggle", int'(ts.clock_en), 1);

    // simultaneous keys
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    press(1, 1, 0, 0);
    chk("mode_over_next", int'(ts.edit_field), 4);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    press(0, 0, 1, 1);
    press_n(0, 1, 0, 0, 3);
    chk("incdec_cancel", int'(dut_set()), 24'h000009);

    // blink cadence, key restart, then timeout
    set_cur(5, 5, 5);
    press(1, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("blink_phase", int'(ts.blink_off), (k / 4) % 2);
    end
    press(0, 0, 1, 0);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      chk("tmo_field_hold", int'(ts.edit_field), 1);
      chk("blink_phase2", int'(ts.blink_off), (k / 4) % 2);
    end
    @(negedge clk);
    st = 0;
    chk("tmo_idle", int'(ts.edit_field), 0);
    chk("tmo_blink", int'(ts.blink_off), 0);
    chk("tmo_set_kept", int'(dut_set()), 24'h000009);

    // reset in the middle of a seconds edit
    press(1, 0, 0, 0);
    press_n(0, 1, 0, 0, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_set",   int'(dut_set()), 0);
    chk("mid_rst_alarm", int'(dut_alarm()), 0);
    chk("mid_rst_en",    int'(ts.clock_en), 0);
    chk("mid_rst_field", int'(ts.edit_field), 0);
    chk("mid_rst_strb",  int'(ts.set_time_finish), 0);
    rst = 1'b0;
    model_reset();

    // randomized key traffic against the model
    for (int n = 0; n < 400; n++) begin
      set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      r = $urandom_range(0, 99);
      if (r < 12)      press(1, 0, 0, 0);
      else if (r < 34) press(0, 1, 0, 0);
      else if (r < 60) press(0, 0, 1, 0);
      else if (r < 86) press(0, 0, 0, 1);
      else if (r < 92) press(0, 0, 1, 1);
      else if (r < 96) press(1, 1, 0, 0);
      else             press(0, 1, 1, 0);
    end
    repeat (2) @(negedge clk);
    chk("rand_set",   int'(dut_set()), int'({bcd(sh), bcd(sm), bcd(ss)}));
    chk("rand_alarm", int'(dut_alarm()), int'({bcd(ah), bcd(am)}));
    chk("pending_commits", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Key-driven editor that produces the time-set and alarm-set interface consumed by time_control.
- Drives the BCD digit buses and the set_time_finish strobe.
- Turns four debounced single-cycle key pulses into edits of hour/min/sec and alarm hour/min.
- Loads working values from the running time on entry; outputs a field cursor and blink flag for display_ctrl.

Parameters:
BLINK_HALF, 12_500_000, cycles per blink half-period (0.25 s at 50 MHz)
TIMEOUT_CYC, 500_000_000, idle-key cycles in any edit state before abort (10 s at 50 MHz)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
key_mode  input  1  one-cycle pulse: enter/advance/abort mode
key_next  input  1  one-cycle pulse: next field / commit
key_inc  input  1  one-cycle pulse: increment field; toggle alarm enable in IDLE
key_dec  input  1  one-cycle pulse: decrement field
cur_sec_ge, cur_sec_shi, cur_min_ge, cur_min_shi, cur_hour_ge, cur_hour_shi  input  4 each  running time, BCD
set_sec_ge, set_sec_shi, set_min_ge, set_min_shi, set_hour_ge, set_hour_shi  output  4 each  time to load, BCD, held
set_time_finish  output  1  one-cycle load strobe
clock_en  output  1  alarm enable
clock_min_ge, clock_min_shi, clock_hour_ge, clock_hour_shi  output  4 each  alarm time, BCD, held
edit_field  output  3  0 none, 1 T_HOUR, 2 T_MIN, 3 T_SEC, 4 A_HOUR, 5 A_MIN
blink_off  output  1  1 = display blanks the cursor field

Behaviour:
- Reset: all set_* = 0, set_time_finish = 0, clock_en = 0, all clock_* = 0, edit_field = 0, blink_off = 0, state IDLE, timers = 0.
- States: IDLE, T_HOUR, T_MIN, T_SEC, T_COMMIT, A_HOUR, A_MIN, A_COMMIT.
- Key priority within one cycle: key_mode > key_next > inc/dec. Only the highest-priority key acts.
- key_inc and key_dec together, with no higher-priority key: no action, but the timeout and blink timers still restart.
- IDLE:
  - key_mode: load the working time regs from cur_*, go to T_HOUR.
  - key_inc or key_dec: toggle clock_en.
- T_HOUR -> T_MIN -> T_SEC on key_next.
- key_next in T_SEC: go to T_COMMIT.
- T_COMMIT, one cycle:
  - set_* <= working time; set_time_finish = 1 in this cycle only.
  - set_* are already valid in the same cycle the strobe is high.
  - Then go to IDLE. Keys arriving in T_COMMIT are ignored.
- key_mode in any T_* state: discard the time edits, load the working alarm regs from clock_*, go to A_HOUR.
- A_HOUR -> A_MIN on key_next.
- key_next in A_MIN: go to A_COMMIT.
- A_COMMIT, one cycle: clock_* <= working alarm, then go to IDLE. clock_en is unchanged.
- key_mode in any A_* state: discard the alarm edits, go to IDLE.
- Field arithmetic (packed two-digit BCD, always a legal value):
  - hour: 00..23. inc wraps 23 -> 00; dec wraps 00 -> 23.
  - min/sec: 00..59. inc wraps 59 -> 00; dec wraps 00 -> 59.
  - ge carry/borrow: 09 -> 10, 10 -> 09, 19 -> 20.
- Latency: key at cycle n; working reg, state and edit_field update at n+1.
- edit_field decodes the state registered: 0 in IDLE/T_COMMIT/A_COMMIT.
- Blink:
  - Counter runs only while edit_field != 0.
  - blink_off toggles every BLINK_HALF cycles.
  - Forced to 0, with the counter cleared, on any key pulse and on every state change.
  - blink_off = 0 whenever edit_field = 0.
- Timeout:
  - Counter clears on any key pulse and on every state change.
  - Reaching TIMEOUT_CYC-1 in any edit state: go to IDLE, no commit, no strobe, outputs unchanged.
  - Never counts in IDLE.
- Reset asserted mid-edit or during a commit cycle: immediately to the reset values; no strobe is emitted.
- The cur_* inputs are sampled only on the IDLE key_mode cycle; later changes do not affect the working regs.
- set_* and clock_* change only in their COMMIT cycle.

Test Plan:
- Reset, then cur = 12:34:56; key_mode, key_next x3 -> set_* = 1,2,3,4,5,6 (hour_shi..sec_ge); set_time_finish high exactly 1 cycle; edit_field sequence 1,2,3,0.
- key_mode; key_inc x12 in T_HOUR from 12 -> hour 00; key_dec once -> 23; commit -> set_hour_shi = 2, set_hour_ge = 3.
- In T_MIN from 59: key_inc -> 00. In T_SEC from 00: key_dec -> 59. From 09: key_inc -> 10 (ge 0, shi 1). All verified via committed set_*.
- Alarm path: key_mode, key_mode (enters A_HOUR, no strobe); set 07:30, key_next x2 -> clock_hour 0/7, clock_min 3/0; clock_en unchanged; then key_inc in IDLE -> clock_en = 1.
- Same-cycle keys: key_mode + key_next in T_MIN -> A_HOUR. key_inc + key_dec -> field unchanged.
- BLINK_HALF = 4, TIMEOUT_CYC = 20: blink_off toggles every 4 cycles in T_HOUR and a key clears it to 0; 20 cycles idle -> IDLE, no strobe, set_* unchanged. Reset mid-T_SEC -> all outputs 0 next cycle.
